// File: rtl/memory_stage_module.sv
// MEM pipeline stage: EX/MEM latch, branch resolution back to IF, word-addressed
// data memory, and MEM/WB latch feeding write-back.
module memory_stage_module #(
  parameter int unsigned ADDR_BITS  = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] add_result,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] read_data2,
  input  logic [4:0]            mux_out,
  input  logic                  zero_out,
  input  logic                  MemtoReg,
  input  logic                  RegWrite,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  Branch,
  output logic                  PCSrc,
  output logic [DATA_WIDTH-1:0] branch_target,
  output logic [DATA_WIDTH-1:0] read_data_wb,
  output logic [DATA_WIDTH-1:0] alu_result_wb,
  output logic [4:0]            write_reg_wb,
  output logic                  RegWrite_wb,
  output logic                  MemtoReg_wb,
  output logic                  mem_fault
);

  localparam int unsigned MEM_DEPTH = 32'(1) << ADDR_BITS;
  localparam int unsigned REG_BITS  = 5;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] add_result;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] store_data;
    logic [REG_BITS-1:0]   write_reg;
    logic                  zero;
    logic                  memtoreg;
    logic                  regwrite;
    logic                  memread;
    logic                  memwrite;
    logic                  branch;
  } ex_mem_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] read_data;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [REG_BITS-1:0]   write_reg;
    logic                  regwrite;
    logic                  memtoreg;
  } mem_wb_t;

  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;
  logic    mem_fault_q, mem_fault_d;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_BITS-1:0]  word_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  misaligned;
  logic                  mem_we;

  // Address decode; upper address bits are dropped so accesses wrap.
  always_comb begin
    word_idx   = ex_mem_q.alu_result[ADDR_BITS+1:2];
    rd_word    = mem_q[word_idx];
    misaligned = (ex_mem_q.alu_result[1:0] != 2'b00) &
                 (ex_mem_q.memread | ex_mem_q.memwrite);
    mem_we     = ex_mem_q.memwrite & ~misaligned & ~stall & ~reset;
  end

  // EX/MEM next state: flush inserts a bubble and wins over stall.
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (flush) begin
      ex_mem_d            = '0;
      ex_mem_d.add_result = add_result;
      ex_mem_d.alu_result = alu_result;
      ex_mem_d.store_data = read_data2;
      ex_mem_d.write_reg  = mux_out;
      ex_mem_d.zero       = zero_out;
    end else if (!stall) begin
      ex_mem_d.add_result = add_result;
      ex_mem_d.alu_result = alu_result;
      ex_mem_d.store_data = read_data2;
      ex_mem_d.write_reg  = mux_out;
      ex_mem_d.zero       = zero_out;
      ex_mem_d.memtoreg   = MemtoReg;
      ex_mem_d.regwrite   = RegWrite;
      ex_mem_d.memread    = MemRead;
      ex_mem_d.memwrite   = MemWrite;
      ex_mem_d.branch     = Branch;
    end
  end

  // MEM/WB next state and sticky fault flag; a misaligned load never writes back.
  always_comb begin
    mem_wb_d    = mem_wb_q;
    mem_fault_d = mem_fault_q | (misaligned & ~stall);
    if (!stall) begin
      mem_wb_d.read_data  = (ex_mem_q.memread & ~misaligned) ? rd_word : '0;
      mem_wb_d.alu_result = ex_mem_q.alu_result;
      mem_wb_d.write_reg  = ex_mem_q.write_reg;
      mem_wb_d.regwrite   = ex_mem_q.regwrite & ~(misaligned & ex_mem_q.memread);
      mem_wb_d.memtoreg   = ex_mem_q.memtoreg;
    end
  end

  // Pipeline latches with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem_q    <= '0;
      mem_wb_q    <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      ex_mem_q    <= ex_mem_d;
      mem_wb_q    <= mem_wb_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  // Data memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[word_idx] <= ex_mem_q.store_data;
    end
  end

  // Outputs are driven straight from the latches.
  assign PCSrc         = ex_mem_q.branch & ex_mem_q.zero;
  assign branch_target = ex_mem_q.add_result;
  assign read_data_wb  = mem_wb_q.read_data;
  assign alu_result_wb = mem_wb_q.alu_result;
  assign write_reg_wb  = mem_wb_q.write_reg;
  assign RegWrite_wb   = mem_wb_q.regwrite;
  assign MemtoReg_wb   = mem_wb_q.memtoreg;
  assign mem_fault     = mem_fault_q;

endmodule

// File: doc/memory_stage_module.md
Name: memory_stage_module

Overview:
- Pipeline MEM stage, directly downstream of the execution stage.
- Registers EX results into an EX/MEM latch, resolves the branch (PCSrc, target) back to IF, and accesses a word-addressed data memory.
- Registers the load data, ALU result and WB controls into a MEM/WB latch feeding write-back.
- Supports stall (hold) and flush (bubble insertion).

Parameters:
- ADDR_BITS, 8, word-address width; data memory holds 2^ADDR_BITS 32-bit words.
- DATA_WIDTH, 32, datapath width; fixed at 32 for this core.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold both latches and suppress memory write this cycle
- flush  in  1  load a bubble into EX/MEM: all control bits cleared
- add_result  in  32  branch target from EX
- alu_result  in  32  ALU result / memory byte address from EX
- read_data2  in  32  store data from EX
- mux_out  in  5  destination register from EX
- zero_out  in  1  ALU zero flag from EX
- MemtoReg, RegWrite, MemRead, MemWrite, Branch  in  1 each  controls from EX
- PCSrc  out  1  branch taken, to IF
- branch_target  out  32  registered add_result, to IF
- read_data_wb  out  32  load data, to WB
- alu_result_wb  out  32  registered ALU result, to WB
- write_reg_wb  out  5  destination register, to WB
- RegWrite_wb, MemtoReg_wb  out  1 each  WB controls
- mem_fault  out  1  sticky misaligned-access flag

Behaviour:
- Reset (clk edge with reset=1):
  - All EX/MEM and MEM/WB registers and mem_fault go to 0.
  - PCSrc is 0 and branch_target is 0 on the following cycle.
  - Data memory contents are not cleared.
  - Reset overrides stall and flush. A store in flight at reset is not performed.
- EX/MEM latch, updated on each rising edge:
  - If reset: clear.
  - Else if flush: data fields load normally; MemtoReg, RegWrite, MemRead, MemWrite and Branch load 0. Flush wins over stall.
  - Else if stall: hold.
  - Else: load all inputs.
- Branch resolution, combinational from the EX/MEM latch:
  - PCSrc = Branch_m & zero_m.
  - branch_target = add_result_m.
  - Valid 1 cycle after the instruction is in EX.
- Address decode:
  - Word index = alu_result_m[ADDR_BITS+1:2].
  - Upper bits are ignored, so the address wraps modulo 2^ADDR_BITS words.
  - misaligned = (alu_result_m[1:0] != 0) & (MemRead_m | MemWrite_m).
- Store:
  - Memory write at the clk edge when MemWrite_m & ~misaligned & ~stall & ~reset.
  - Data written is read_data2_m.
- Load:
  - Asynchronous read of the word index, captured into read_data_wb at the edge.
  - read_data_wb = 0 if MemRead_m=0 or misaligned.
  - MemRead_m and MemWrite_m both set: the write is performed and the read returns the pre-write (old) word.
- MEM/WB latch, updated on each rising edge:
  - If reset: clear.
  - Else if stall: hold.
  - Else: load read_data, alu_result_m, write_reg_m, RegWrite_m, MemtoReg_m.
  - RegWrite_wb is forced to 0 for a misaligned load.
- mem_fault:
  - Set at the edge when misaligned and not stalled.
  - Cleared only by reset.
- Latency: EX inputs to WB outputs is 2 clk edges; a store is visible to a load issued in the next cycle.

Test Plan:
- Store then load: cycle0 MemWrite=1, alu_result=0x10, read_data2=0xDEADBEEF; cycle1 MemRead=1, MemtoReg=1, RegWrite=1, alu_result=0x10, mux_out=5 -> 2 edges later read_data_wb=0xDEADBEEF, write_reg_wb=5, RegWrite_wb=1.
- Branch: Branch=1, zero_out=1, add_result=0x40 -> PCSrc=1 and branch_target=0x40 exactly one cycle later. Same stimulus with zero_out=0 -> PCSrc=0.
- Misaligned and wrap: store to 0x12 -> memory unchanged and mem_fault=1, held until reset. With ADDR_BITS=8, a store to 0x400 then a load from 0x000 returns the stored word.
- Stall and flush:
  - stall=1 for 3 cycles during a store -> exactly one write occurs; outputs hold.
  - flush=1 on a Branch=1, zero=1 instruction -> PCSrc stays 0 and RegWrite_wb=0.
  - flush=1 with stall=1 -> bubble inserted.
- Reset mid-operation: reset=1 on the edge where a store would occur -> memory word unchanged; all outputs 0 the next cycle.
